// File: rtl/jk_reg_arbiter_if.sv
// Request/response bundle for the shared JK register controller.
// Two requester command channels plus the register state and completion status.
interface jk_reg_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_mode;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_mode;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             err;

    modport slave (
        input  req0_valid, req0_mode, req0_a, req0_b,
        input  req1_valid, req1_mode, req1_a, req1_b,
        output req0_ready, req1_ready,
        output Q, Qb, busy, done, done_id, err
    );

    modport master (
        output req0_valid, req0_mode, req0_a, req0_b,
        output req1_valid, req1_mode, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  Q, Qb, busy, done, done_id, err
    );
endinterface

// File: rtl/jk_reg_arbiter.sv
// Round-robin controller sharing a JK-flip-flop register between two requesters.
// Each command runs IDLE -> LOAD (J/K build) -> APPLY (Q update) -> RESP (done pulse).
module jk_reg_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    jk_reg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        APPLY = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             err_lat_q, err_lat_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q, qb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             err_q, err_d;

    logic grant0_c, grant1_c;
    logic ready0_c, ready1_c;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant0_c = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1_c = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        ready0_c = (state_q == IDLE) && grant0_c;
        ready1_c = (state_q == IDLE) && grant1_c;
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        j_d          = j_q;
        k_d          = k_q;
        err_lat_d    = err_lat_q;
        q_d          = q_q;

        case (state_q)
            IDLE: begin
                if (ready0_c) begin
                    mode_d       = bus.req0_mode;
                    a_d          = bus.req0_a;
                    b_d          = bus.req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = LOAD;
                end else if (ready1_c) begin
                    mode_d       = bus.req1_mode;
                    a_d          = bus.req1_a;
                    b_d          = bus.req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                err_lat_d = 1'b0;
                case (mode_q)
                    MODE_D: begin
                        j_d = a_q;
                        k_d = ~a_q;
                    end
                    MODE_T: begin
                        j_d = a_q;
                        k_d = a_q;
                    end
                    // S=R=1 bits fall out as J=K=0, i.e. hold.
                    MODE_SR: begin
                        j_d       = a_q & ~b_q;
                        k_d       = b_q & ~a_q;
                        err_lat_d = |(a_q & b_q);
                    end
                    MODE_JK: begin
                        j_d = a_q;
                        k_d = b_q;
                    end
                    default: begin
                        j_d = '0;
                        k_d = '0;
                    end
                endcase
                state_d = APPLY;
            end
            APPLY: begin
                q_d     = (j_q & ~q_q) | (~k_q & q_q);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        qb_d      = ~q_d;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == RESP);
        done_id_d = (state_d == RESP) ? id_q : done_id_q;
        err_d     = (state_d == RESP) ? err_lat_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            j_q          <= '0;
            k_q          <= '0;
            err_lat_q    <= 1'b0;
            q_q          <= '0;
            qb_q         <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            j_q          <= j_d;
            k_q          <= k_d;
            err_lat_q    <= err_lat_d;
            q_q          <= q_d;
            qb_q         <= qb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.Qb      = qb_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// Self-checking bench for jk_reg_arbiter: directed scenarios plus randomized
// commands checked against a per-bit flip-flop behaviour model.
module tb_jk_reg_arbiter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    jk_reg_arbiter_if #(.WIDTH(W)) bus ();

    jk_reg_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: register contents and who was served last.
    logic [W-1:0] exp_q;
    logic         exp_last;

    function automatic logic [W-1:0] model_q(input logic [W-1:0] q, input logic [1:0] mode,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] n;
        n = q;
        for (int i = 0; i < int'(W); i++) begin
            case (mode)
                2'd0: n[i] = a[i];
                2'd1: if (a[i]) n[i] = ~q[i];
                2'd2: begin
                    if (a[i] && !b[i])      n[i] = 1'b1;
                    else if (b[i] && !a[i]) n[i] = 1'b0;
                end
                default: begin
                    if (a[i] && b[i]) n[i] = ~q[i];
                    else if (a[i])    n[i] = 1'b1;
                    else if (b[i])    n[i] = 1'b0;
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic model_err(input logic [1:0] mode, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        return (mode == 2'd2) && ((a & b) != '0);
    endfunction

    task automatic set_req(input logic id, input logic v, input logic [1:0] m,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (!id) begin
            bus.req0_valid = v; bus.req0_mode = m; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_mode = m; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Called just after the accept edge; walks LOAD, APPLY, RESP and the following IDLE cycle.
    task automatic follow(input logic id, input logic [1:0] mode, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] nq;
        logic         e;
        nq = model_q(exp_q, mode, a, b);
        e  = model_err(mode, a, b);

        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Q !== exp_q) begin
            failures++;
            $display("FAIL load_cycle busy=%b done=%b Q=%h required busy=1 done=0 Q=%h",
                     bus.busy, bus.done, bus.Q, exp_q);
        end
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_load ready0=%b ready1=%b required 0 0", bus.req0_ready, bus.req1_ready);
        end

        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.Q !== exp_q) begin
            failures++;
            $display("FAIL apply_cycle busy=%b done=%b Q=%h required busy=1 done=0 Q=%h",
                     bus.busy, bus.done, bus.Q, exp_q);
        end
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_apply ready0=%b ready1=%b required 0 0", bus.req0_ready, bus.req1_ready);
        end

        @(negedge clk);
        checks++;
        if (bus.Q !== nq || bus.Qb !== ~nq) begin
            failures++;
            $display("FAIL q_update Q=%h Qb=%h required Q=%h Qb=%h", bus.Q, bus.Qb, nq, ~nq);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== id || bus.err !== e || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL resp_cycle done=%b done_id=%b err=%b busy=%b required 1 %b %b 1",
                     bus.done, bus.done_id, bus.err, bus.busy, id, e);
        end
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_resp ready0=%b ready1=%b required 0 0", bus.req0_ready, bus.req1_ready);
        end
        exp_q    = nq;
        exp_last = id;

        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle busy=%b done=%b err=%b required 0 0 0", bus.busy, bus.done, bus.err);
        end
    endtask

    // Single requester command; starts at a negedge, ends at the negedge of the IDLE cycle.
    task automatic exec_cmd(input logic id, input logic [1:0] mode, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        set_req(id, 1'b1, mode, a, b);
        for (int i = 0; i < 16; i++) begin
            #1;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout id=%0d ready=0 required 1 within 16 cycles", id);
            set_req(id, 1'b0, mode, a, b);
            return;
        end
        checks++;
        if ((id ? bus.req0_ready : bus.req1_ready) !== 1'b0) begin
            failures++;
            $display("FAIL both_ready other_ready=1 required 0");
        end
        @(posedge clk);
        #1;
        set_req(id, 1'b0, mode, a, b);
        follow(id, mode, a, b);
    endtask

    // Both requesters valid together; winner predicted from the model's last grant.
    task automatic contend(input logic [1:0] m0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [1:0] m1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        logic win;
        win = exp_last ? 1'b0 : 1'b1;
        set_req(1'b0, 1'b1, m0, a0, b0);
        set_req(1'b1, 1'b1, m1, a1, b1);
        #1;
        checks++;
        if (bus.req0_ready !== !win || bus.req1_ready !== win) begin
            failures++;
            $display("FAIL tie_grant ready0=%b ready1=%b required %b %b",
                     bus.req0_ready, bus.req1_ready, !win, win);
            set_req(1'b0, 1'b0, m0, a0, b0);
            set_req(1'b1, 1'b0, m1, a1, b1);
            @(negedge clk);
            return;
        end
        @(posedge clk);
        #1;
        if (!win) begin
            set_req(1'b0, 1'b0, m0, a0, b0);
            follow(1'b0, m0, a0, b0);
        end else begin
            set_req(1'b1, 1'b0, m1, a1, b1);
            follow(1'b1, m1, a1, b1);
        end
        #1;
        checks++;
        if ((win ? bus.req0_ready : bus.req1_ready) !== 1'b1) begin
            failures++;
            $display("FAIL loser_next ready=0 required 1 in first idle cycle");
            set_req(1'b0, 1'b0, m0, a0, b0);
            set_req(1'b1, 1'b0, m1, a1, b1);
            @(negedge clk);
            return;
        end
        @(posedge clk);
        #1;
        if (win) begin
            set_req(1'b0, 1'b0, m0, a0, b0);
            follow(1'b0, m0, a0, b0);
        end else begin
            set_req(1'b1, 1'b0, m1, a1, b1);
            follow(1'b1, m1, a1, b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.Q !== '0 || bus.Qb !== '1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0) begin
            failures++;
            $display("FAIL %s Q=%h Qb=%h busy=%b done=%b err=%b required 00 ff 0 0 0",
                     tag, bus.Q, bus.Qb, bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_reset();
        set_req(1'b0, 1'b0, 2'd0, '0, '0);
        set_req(1'b1, 1'b0, 2'd0, '0, '0);
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset_values");
        checks++;
        if (bus.done_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_id done_id=%b required 0", bus.done_id);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        exp_q    = '0;
        exp_last = 1'b1;
    endtask

    task automatic test_d_mode();
        exec_cmd(1'b0, 2'd0, 8'hA5, W'($urandom));
        checks++;
        if (bus.Q !== 8'hA5) begin
            failures++;
            $display("FAIL d_mode Q=%h required a5", bus.Q);
        end
    endtask

    task automatic test_t_mode();
        exec_cmd(1'b1, 2'd1, 8'h0F, W'($urandom));
        checks++;
        if (bus.Q !== 8'hAA) begin
            failures++;
            $display("FAIL t_mode Q=%h required aa", bus.Q);
        end
    endtask

    task automatic test_sr_conflict();
        exec_cmd(1'b0, 2'd2, 8'hF0, 8'h3C);
        checks++;
        if (bus.Q !== 8'hE2) begin
            failures++;
            $display("FAIL sr_conflict Q=%h required e2", bus.Q);
        end
    endtask

    task automatic test_contention();
        contend(2'd3, 8'hFF, 8'hFF, 2'd0, 8'h3C, W'($urandom));
        // Asynchronous reset while idle with a known value, then a fresh tie goes to req0.
        exec_cmd(1'b0, 2'd0, 8'h5A, '0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_idle");
        @(negedge clk);
        rst_n    = 1'b1;
        exp_q    = '0;
        exp_last = 1'b1;
        contend(2'd3, 8'hFF, 8'hFF, 2'd0, 8'h3C, W'($urandom));
        checks++;
        if (bus.Q !== 8'h3C) begin
            failures++;
            $display("FAIL contention_final Q=%h required 3c", bus.Q);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 1'b0;
        set_req(1'b0, 1'b1, 2'd0, 8'hFF, '0);
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.req0_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_mid_accept ready=0 required 1");
        end
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 2'd0, 8'hFF, '0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_apply");
        @(negedge clk);
        rst_n    = 1'b1;
        exp_q    = '0;
        exp_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.Q !== '0) begin
                failures++;
                $display("FAIL reset_mid_quiet done=%b Q=%h required 0 00", bus.done, bus.Q);
            end
        end
        exec_cmd(1'b1, 2'd0, 8'h81, '0);
    endtask

    task automatic test_drop_valid();
        fork
            exec_cmd(1'b0, 2'd1, W'($urandom), W'($urandom));
            begin
                @(negedge clk);
                @(negedge clk);
                set_req(1'b1, 1'b1, 2'd0, 8'hFF, '0);
                @(negedge clk);
                set_req(1'b1, 1'b0, 2'd0, 8'hFF, '0);
            end
        join
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.Q !== exp_q) begin
                failures++;
                $display("FAIL drop_valid busy=%b Q=%h required 0 %h", bus.busy, bus.Q, exp_q);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            if (kind == 2)
                contend(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                        2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
            else
                exec_cmd(1'(kind), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_d_mode();
        test_t_mode();
        test_sr_conflict();
        test_contention();
        test_reset_mid();
        test_drop_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
